multicycle_controller: RTL

Sequencing control unit for the multicycle MIPS datapath. It decodes the latched instruction's `op`/`funct` fields and steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the same strobe set as the single-cycle decoder plus PC/IR write enables. It adds a memory request/ready handshake with a parametrised timeout, a selectable syscall mode, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and the datapath muxes, ALU, register file and the shared memory port.

---
 rtl/multicycle_controller_if.sv | 45 ++++
 rtl/multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the datapath:
// instruction fields and status in, datapath strobes and counters out.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             pc_we;
  logic             ir_we;
  logic [3:0]       aluop;
  logic             reg_dst;
  logic             reg_we;
  logic             mem_to_reg;
  logic             alu_src;
  logic             shift;
  logic             branch;
  logic             equ;
  logic             jump;
  logic             jump_reg;
  logic             jal;
  logic             usign;
  logic             sys;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct, alu_zero, mem_ready,
    output mem_req, mem_we, pc_we, ir_we, aluop, reg_dst, reg_we, mem_to_reg,
           alu_src, shift, branch, equ, jump, jump_reg, jal, usign, sys,
           halted, illegal, timeout, retired
  );

  modport slave (
    output op, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, pc_we, ir_we, aluop, reg_dst, reg_we, mem_to_reg,
           alu_src, shift, branch, equ, jump, jump_reg, jal, usign, sys,
           halted, illegal, timeout, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with memory
// handshake timeout, illegal-opcode trap, syscall mode and retire counter.
module multicycle_controller #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 0,
  parameter bit          SYS_HALT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SYS  = 6'b001100;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRA  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q, timeout_q;

  logic       r_type, legal, is_beq, is_bne, is_j, is_jal, is_jr, is_sys, is_lw, is_sw;
  logic [3:0] alu_dec;
  logic       wait_hit, retire, set_ill, set_tmo;
  logic       mem_req_c, mem_we_c, pc_we_c, ir_we_c, reg_dst_c, reg_we_c, mem_to_reg_c;
  logic       alu_src_c, shift_c, branch_c, equ_c, jump_c, jump_reg_c, jal_c, usign_c, sys_c;
  logic [3:0] aluop_c;

  assign r_type = (bus.op == OP_RTYPE);
  assign is_beq = (bus.op == OP_BEQ);
  assign is_bne = (bus.op == OP_BNE);
  assign is_j   = (bus.op == OP_J);
  assign is_jal = (bus.op == OP_JAL);
  assign is_lw  = (bus.op == OP_LW);
  assign is_sw  = (bus.op == OP_SW);
  assign is_jr  = r_type && (bus.funct == FN_JR);
  assign is_sys = r_type && (bus.funct == FN_SYS);

  // Instruction legality and ALU operation from op/funct
  always_comb begin
    legal   = 1'b1;
    alu_dec = ALU_ADD;
    if (r_type) begin
      case (bus.funct)
        FN_ADD, FN_ADDU, FN_JR, FN_SYS: alu_dec = ALU_ADD;
        FN_SUB:                         alu_dec = ALU_SUB;
        FN_AND:                         alu_dec = ALU_AND;
        FN_OR:                          alu_dec = ALU_OR;
        FN_NOR:                         alu_dec = ALU_NOR;
        FN_SLT:                         alu_dec = ALU_SLT;
        FN_SLTU:                        alu_dec = ALU_SLTU;
        FN_SLL, FN_SLLV:                alu_dec = ALU_SLL;
        FN_SRA, FN_SRAV:                alu_dec = ALU_SRA;
        FN_SRL:                         alu_dec = ALU_SRL;
        default:                        legal   = 1'b0;
      endcase
    end else begin
      case (bus.op)
        OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_dec = ALU_ADD;
        OP_BEQ, OP_BNE:                                alu_dec = ALU_SUB;
        OP_ANDI:                                       alu_dec = ALU_AND;
        OP_ORI:                                        alu_dec = ALU_OR;
        OP_SLTI:                                       alu_dec = ALU_SLT;
        default:                                       legal   = 1'b0;
      endcase
    end
  end

  // Hit on the TIMEOUT-th consecutive unanswered request cycle
  assign wait_hit = (TIMEOUT != 0) && !bus.mem_ready && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_req_c && !bus.mem_ready) wait_q <= wait_q + WAIT_W'(1);
      else if (mem_req_c)              wait_q <= '0;
      if (retire)  retired_q <= retired_q + CNT_W'(1);
      if (set_ill) illegal_q <= 1'b1;
      if (set_tmo) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    pc_we_c      = 1'b0;
    ir_we_c      = 1'b0;
    reg_dst_c    = 1'b0;
    reg_we_c     = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_c    = 1'b0;
    shift_c      = 1'b0;
    branch_c     = 1'b0;
    equ_c        = 1'b0;
    jump_c       = 1'b0;
    jump_reg_c   = 1'b0;
    jal_c        = 1'b0;
    usign_c      = 1'b0;
    sys_c        = 1'b0;
    aluop_c      = ALU_ADD;
    retire       = 1'b0;
    set_ill      = 1'b0;
    set_tmo      = 1'b0;

    // ALU controls stay valid from EXEC through the end of the instruction
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      aluop_c   = alu_dec;
      alu_src_c = !r_type && !is_beq && !is_bne;
      shift_c   = r_type && (bus.funct inside {FN_SLL, FN_SRL, FN_SRA});
      usign_c   = (r_type && (bus.funct == FN_ADDU)) || (bus.op == OP_ADDIU);
    end

    case (state_q)
      S_RST: begin
        aluop_c = 4'b0000;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          set_tmo = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          set_ill = 1'b1;
          state_d = S_HALT;
        end else if (is_j || is_jal) begin
          jump_c   = 1'b1;
          pc_we_c  = 1'b1;
          jal_c    = is_jal;
          reg_we_c = is_jal;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          branch_c = 1'b1;
          equ_c    = is_beq;
          pc_we_c  = is_beq ? bus.alu_zero : !bus.alu_zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jr) begin
          jump_reg_c = 1'b1;
          pc_we_c    = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (is_sys) begin
          if (SYS_HALT) begin
            state_d = S_HALT;
          end else begin
            sys_c   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_sw;
        if (bus.mem_ready) begin
          retire  = is_sw;
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_hit) begin
          set_tmo = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = r_type;
        mem_to_reg_c = is_lw;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.pc_we      = pc_we_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.aluop      = aluop_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.reg_we     = reg_we_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.alu_src    = alu_src_c;
  assign bus.shift      = shift_c;
  assign bus.branch     = branch_c;
  assign bus.equ        = equ_c;
  assign bus.jump       = jump_c;
  assign bus.jump_reg   = jump_reg_c;
  assign bus.jal        = jal_c;
  assign bus.usign      = usign_c;
  assign bus.sys        = sys_c;
  assign bus.halted     = (state_q == S_HALT);
  // Illegal is visible already in the trapping DECODE cycle
  assign bus.illegal    = illegal_q | set_ill;
  assign bus.timeout    = timeout_q;
  assign bus.retired    = retired_q;

endmodule
